// File: rtl/instruction_queue_pkg.sv
// Shared definitions for the fetch-to-issue instruction queue: entry layout,
// default depth and the small count-decoding helpers used by the queue.
package instruction_queue_pkg;

  localparam int IQ_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  // Fetch offers 0..2; the reserved encoding 3 means nothing is offered.
  function automatic logic [1:0] push_limit(input logic [1:0] offered);
    return (offered == 2'd3) ? 2'd0 : offered;
  endfunction

  // Issue consumes 0..2; an encoding of 3 is clamped to a dual pop.
  function automatic logic [1:0] pop_limit(input logic [1:0] requested);
    return (requested == 2'd3) ? 2'd2 : requested;
  endfunction

endpackage

// File: rtl/instruction_queue.sv
// Decoupling FIFO between fetch and the dual-issue scheduler: accepts up to two
// instructions per cycle and presents the two oldest entries on slot0/slot1.
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int  DEPTH = IQ_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [1:0]       in_count,
  input  logic [31:0]      in_inst0,
  input  logic [31:0]      in_pc0,
  input  logic [31:0]      in_inst1,
  input  logic [31:0]      in_pc1,
  output logic             in_ready,
  input  logic [1:0]       pop_count,
  output logic             out_valid0,
  output logic [31:0]      out_inst0,
  output logic [31:0]      out_pc0,
  output logic             out_valid1,
  output logic [31:0]      out_inst1,
  output logic [31:0]      out_pc1,
  output logic [PTR_W:0]   occupancy
);

  localparam logic [PTR_W:0] READY_MAX = (PTR_W + 1)'(DEPTH - 2);
  localparam logic [PTR_W:0] TWO       = (PTR_W + 1)'(2);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_next1;
  logic [PTR_W-1:0] tail_next1;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   push_n;
  logic [PTR_W:0]   pop_want;
  logic [PTR_W:0]   pop_n;
  logic             push_req;
  logic             push_ok;
  iq_entry_t        entry0;
  iq_entry_t        entry1;

  iq_entry_t mem [DEPTH];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    push_req   = 1'b0;
    push_ok    = 1'b0;
    push_n     = '0;
    pop_want   = '0;
    pop_n      = '0;
    in_ready   = 1'b0;
    head_next1 = head + PTR_W'(1);
    tail_next1 = tail + PTR_W'(1);

    // in_ready depends only on registered occupancy, so a same-cycle pop
    // cannot re-open the input; it rises the cycle after occupancy drops.
    in_ready = (count <= READY_MAX);
    push_req = (push_limit(in_count) != 2'd0);
    push_ok  = push_req && in_ready && !flush;
    push_n   = push_ok ? (PTR_W + 1)'(push_limit(in_count)) : '0;

    // Pop is bounded by the pre-push occupancy, so an empty queue ignores it.
    pop_want = (PTR_W + 1)'(pop_limit(pop_count));
    pop_n    = (pop_want > count) ? count : pop_want;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + pop_n[PTR_W-1:0];
      tail  <= tail + push_n[PTR_W-1:0];
      count <= count + push_n - pop_n;
    end
  end

  // NOTE: entry storage has no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail] <= '{pc: in_pc0, inst: in_inst0};
      if (push_n == TWO) begin
        mem[tail_next1] <= '{pc: in_pc1, inst: in_inst1};
      end
    end
  end

  always_comb begin
    entry0     = mem[head];
    entry1     = mem[head_next1];
    out_valid0 = (count != '0);
    out_valid1 = (count >= TWO);
    out_inst0  = out_valid0 ? entry0.inst : '0;
    out_pc0    = out_valid0 ? entry0.pc   : '0;
    out_inst1  = out_valid1 ? entry1.inst : '0;
    out_pc1    = out_valid1 ? entry1.pc   : '0;
    occupancy  = count;
  end

  // Fetch must never offer instructions while the queue cannot take a pair.
  a_no_push_when_not_ready: assert property (
    @(posedge clk) disable iff (!rst_n) push_req |-> in_ready
  );

  a_count_in_range: assert property (
    @(posedge clk) disable iff (!rst_n) count <= (PTR_W + 1)'(DEPTH)
  );

endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: directed scenarios plus random traffic, all
// checked by a negedge monitor against a queue-based reference model.
module tb_instruction_queue;
  import instruction_queue_pkg::*;

  localparam int DEPTH = IQ_DEPTH_DEFAULT;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [1:0]       in_count;
  logic [31:0]      in_inst0;
  logic [31:0]      in_pc0;
  logic [31:0]      in_inst1;
  logic [31:0]      in_pc1;
  logic             in_ready;
  logic [1:0]       pop_count;
  logic             out_valid0;
  logic [31:0]      out_inst0;
  logic [31:0]      out_pc0;
  logic             out_valid1;
  logic [31:0]      out_inst1;
  logic [31:0]      out_pc1;
  logic [PTR_W:0]   occupancy;

  int          checks   = 0;
  int          failures = 0;
  iq_entry_t   exp_q[$];
  int          head_m   = 0;
  bit          mon_en   = 1'b0;
  logic [31:0] next_pc  = 32'h100;

  always #5 clk = ~clk;

  instruction_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_count   (in_count),
    .in_inst0   (in_inst0),
    .in_pc0     (in_pc0),
    .in_inst1   (in_inst1),
    .in_pc1     (in_pc1),
    .in_ready   (in_ready),
    .pop_count  (pop_count),
    .out_valid0 (out_valid0),
    .out_inst0  (out_inst0),
    .out_pc0    (out_pc0),
    .out_valid1 (out_valid1),
    .out_inst1  (out_inst1),
    .out_pc1    (out_pc1),
    .occupancy  (occupancy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the presented slots against the model, then retires
  // whatever the scheduler consumes this cycle (or everything on flush).
  always @(negedge clk) begin
    int sz;
    int take;
    if (mon_en) begin
      sz = exp_q.size();
      check("occupancy", 64'(occupancy), 64'(sz));
      check("in_ready", 64'(in_ready), 64'((DEPTH - sz) >= 2));
      check("out_valid0", 64'(out_valid0), 64'(sz >= 1));
      check("out_valid1", 64'(out_valid1), 64'(sz >= 2));
      check("slot0_pc", 64'(out_pc0), (sz >= 1) ? 64'(exp_q[0].pc) : 64'd0);
      check("slot0_inst", 64'(out_inst0), (sz >= 1) ? 64'(exp_q[0].inst) : 64'd0);
      check("slot1_pc", 64'(out_pc1), (sz >= 2) ? 64'(exp_q[1].pc) : 64'd0);
      check("slot1_inst", 64'(out_inst1), (sz >= 2) ? 64'(exp_q[1].inst) : 64'd0);
      if (flush) begin
        exp_q.delete();
        head_m = 0;
      end else begin
        take = (pop_count == 2'd3) ? 2 : int'(pop_count);
        if (take > sz) take = sz;
        for (int i = 0; i < take; i++) begin
          void'(exp_q.pop_front());
          head_m = (head_m + 1) % DEPTH;
        end
      end
    end
  end

  // One cycle of stimulus, entered and left at posedge+1. Expected entries are
  // committed to the model at the edge that captures them.
  task automatic step(input bit fl, input int cnt, input int pop);
    bit        ready_m;
    bit        accepted;
    iq_entry_t e0;
    iq_entry_t e1;
    ready_m  = (DEPTH - exp_q.size()) >= 2;
    accepted = !fl && ready_m && (cnt == 1 || cnt == 2);
    e0 = '{pc: next_pc, inst: $urandom};
    e1 = '{pc: next_pc + 32'd4, inst: $urandom};
    flush     = fl;
    in_count  = 2'(cnt);
    in_pc0    = e0.pc;
    in_inst0  = e0.inst;
    in_pc1    = e1.pc;
    in_inst1  = e1.inst;
    pop_count = 2'(pop);
    @(posedge clk);
    if (accepted) begin
      exp_q.push_back(e0);
      if (cnt == 2) exp_q.push_back(e1);
      next_pc += 32'(4 * cnt);
    end
    #1;
    flush     = 1'b0;
    in_count  = 2'd0;
    pop_count = 2'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] first_pc;
    logic [31:0] p;
    int          h;
    int          sz;
    int          cnt;

    // Reset held with fetch offering a pair: nothing may be captured.
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_count  = 2'd2;
    in_pc0    = 32'hdead_0000;
    in_inst0  = 32'h1111_1111;
    in_pc1    = 32'hdead_0004;
    in_inst1  = 32'h2222_2222;
    pop_count = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_valid0", 64'(out_valid0), 64'd0);
    check("rst_valid1", 64'(out_valid1), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_pc0", 64'(out_pc0), 64'd0);
    in_count = 2'd0;
    rst_n    = 1'b1;
    mon_en   = 1'b1;

    // Two pairs, no pop.
    step(0, 2, 0);
    step(0, 2, 0);
    check("pairs_slot0_pc", 64'(out_pc0), 64'h100);
    check("pairs_slot1_pc", 64'(out_pc1), 64'h104);
    check("pairs_occupancy", 64'(occupancy), 64'd4);

    // Fill towards full: in_ready drops at DEPTH-1 and rises a cycle after a pop.
    step(0, 2, 0);
    check("fill6_in_ready", 64'(in_ready), 64'd1);
    step(0, 1, 0);
    check("fill7_in_ready", 64'(in_ready), 64'd0);
    step(0, 0, 1);
    check("after_pop_in_ready", 64'(in_ready), 64'd1);
    check("after_pop_occupancy", 64'(occupancy), 64'd6);
    step(0, 2, 0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_occupancy", 64'(occupancy), 64'(DEPTH));
    repeat (DEPTH / 2) step(0, 0, 2);
    check("drained_occupancy", 64'(occupancy), 64'd0);

    // Single entry with a dual pop, then a dual pop on an empty queue.
    step(0, 1, 0);
    h = head_m;
    step(0, 0, 2);
    check("single_pop2_occupancy", 64'(occupancy), 64'd0);
    check("single_pop2_head", 64'(dut.head), 64'((h + 1) % DEPTH));
    step(0, 0, 2);
    check("empty_pop2_occupancy", 64'(occupancy), 64'd0);

    // Steady push2/pop2 stream across several pointer wraps.
    first_pc = next_pc;
    step(0, 2, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 2, 2);
      check("wrap_slot0_pc", 64'(out_pc0), 64'(first_pc + 32'(8 * (i + 1))));
      check("wrap_slot1_pc", 64'(out_pc1), 64'(first_pc + 32'(8 * (i + 1) + 4)));
      check("wrap_occupancy", 64'(occupancy), 64'd2);
    end
    step(0, 0, 2);

    // Flush at occupancy 5 beats a same-cycle push and pop.
    step(0, 2, 0);
    step(0, 2, 0);
    step(0, 1, 0);
    check("pre_flush_occupancy", 64'(occupancy), 64'd5);
    step(1, 2, 1);
    check("flush_occupancy", 64'(occupancy), 64'd0);
    check("flush_valid0", 64'(out_valid0), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    p = next_pc;
    step(0, 1, 0);
    check("post_flush_index0_pc", 64'(dut.mem[0].pc), 64'(p));
    check("post_flush_slot0_pc", 64'(out_pc0), 64'(p));

    // Random traffic; fetch only offers when the model says the queue has room.
    for (int i = 0; i < 600; i++) begin
      sz  = exp_q.size();
      cnt = ((DEPTH - sz) >= 2) ? int'($urandom_range(0, 3)) : 0;
      step($urandom_range(0, 31) == 0, cnt, int'($urandom_range(0, 3)));
    end

    // Reset asserted mid-cycle clears state without waiting for a clock edge.
    step(0, 2, 0);
    step(0, 2, 0);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_occupancy", 64'(occupancy), 64'd0);
    check("async_rst_valid0", 64'(out_valid0), 64'd0);
    check("async_rst_valid1", 64'(out_valid1), 64'd0);
    check("async_rst_pc0", 64'(out_pc0), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    head_m = 0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    p = next_pc;
    step(0, 2, 0);
    check("post_rst_slot0_pc", 64'(out_pc0), 64'(p));
    check("post_rst_occupancy", 64'(occupancy), 64'd2);
    step(0, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
